// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants, colour/count widths and a window helper.
package vga_timing_pkg;

    localparam int COLOR_W   = 4;
    localparam int COUNT_W   = 10;
    localparam int COUNT_MAX = (1 << COUNT_W) - 1;

    localparam int H_TOTAL  = 800;
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 18;
    localparam int H_BACK   = 50;

    localparam int V_TOTAL  = 525;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_BACK   = 33;

    localparam int VIDEO_DELAY_DEF = 2;
    localparam int VIDEO_DELAY_MAX = 7;

    // Inclusive range test used for both sync windows.
    function automatic logic in_window(
        input logic [COUNT_W-1:0] value,
        input logic [COUNT_W-1:0] lo,
        input logic [COUNT_W-1:0] hi
    );
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; every stage resets to RST_VAL.
module vga_delay_line #(
    parameter int              WIDTH   = 3,
    parameter int              DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift din through DEPTH stages; reset clears every stage to RST_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= RST_VAL;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counter with porch-applied syncs and colour blanking, aligned
// through a VIDEO_DELAY pipeline to match the game's pixel latency.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS       = H_TOTAL,
    parameter int TOTAL_ROWS       = V_TOTAL,
    parameter int ACTIVE_COLS      = H_ACTIVE,
    parameter int ACTIVE_ROWS      = V_ACTIVE,
    parameter int FRONT_PORCH_HORZ = H_FRONT,
    parameter int BACK_PORCH_HORZ  = H_BACK,
    parameter int FRONT_PORCH_VERT = V_FRONT,
    parameter int BACK_PORCH_VERT  = V_BACK,
    parameter int VIDEO_DELAY      = VIDEO_DELAY_DEF
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic [COLOR_W-1:0] i_Red_Video,
    input  logic [COLOR_W-1:0] i_Grn_Video,
    input  logic [COLOR_W-1:0] i_Blu_Video,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic [COUNT_W-1:0] o_Col_Count,
    output logic [COUNT_W-1:0] o_Row_Count,
    output logic               o_Frame_Start,
    output logic               o_VGA_HSync,
    output logic               o_VGA_VSync,
    output logic [COLOR_W-1:0] o_VGA_Red,
    output logic [COLOR_W-1:0] o_VGA_Grn,
    output logic [COLOR_W-1:0] o_VGA_Blu
);

    if (TOTAL_COLS > COUNT_MAX || TOTAL_ROWS > COUNT_MAX ||
        ACTIVE_COLS > COUNT_MAX || ACTIVE_ROWS > COUNT_MAX ||
        FRONT_PORCH_HORZ > COUNT_MAX || BACK_PORCH_HORZ > COUNT_MAX ||
        FRONT_PORCH_VERT > COUNT_MAX || BACK_PORCH_VERT > COUNT_MAX) begin : g_width_err
        $error("vga_sync_gen: timing parameter exceeds 10-bit count range");
    end
    if (VIDEO_DELAY < 0 || VIDEO_DELAY > VIDEO_DELAY_MAX) begin : g_delay_err
        $error("vga_sync_gen: VIDEO_DELAY must be 0..7");
    end

    localparam logic [COUNT_W-1:0] COL_LAST = COUNT_W'(TOTAL_COLS - 1);
    localparam logic [COUNT_W-1:0] ROW_LAST = COUNT_W'(TOTAL_ROWS - 1);
    localparam logic [COUNT_W-1:0] ACT_COLS = COUNT_W'(ACTIVE_COLS);
    localparam logic [COUNT_W-1:0] ACT_ROWS = COUNT_W'(ACTIVE_ROWS);
    localparam logic [COUNT_W-1:0] HS_FIRST = COUNT_W'(ACTIVE_COLS + FRONT_PORCH_HORZ);
    localparam logic [COUNT_W-1:0] HS_LAST  = COUNT_W'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
    localparam logic [COUNT_W-1:0] VS_FIRST = COUNT_W'(ACTIVE_ROWS + FRONT_PORCH_VERT);
    localparam logic [COUNT_W-1:0] VS_LAST  = COUNT_W'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

    // Pipeline word: {hsync, vsync, active}; idle is syncs high, blanked.
    localparam logic [2:0] PIPE_IDLE = 3'b110;

    logic [COUNT_W-1:0] col_nxt;
    logic [COUNT_W-1:0] row_nxt;
    logic               hsync_pre;
    logic               vsync_pre;
    logic               active_pre;
    logic [2:0]         pipe_in;
    logic [2:0]         pipe_out;

    // Next raster position: column wraps every line, row wraps with the last column.
    always_comb begin
        col_nxt = o_Col_Count + 1'b1;
        row_nxt = o_Row_Count;
        if (o_Col_Count == COL_LAST) begin
            col_nxt = '0;
            if (o_Row_Count == ROW_LAST) begin
                row_nxt = '0;
            end else begin
                row_nxt = o_Row_Count + 1'b1;
            end
        end
    end

    // Counts and flags register together so the flags always describe the visible counts.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Col_Count   <= col_nxt;
            o_Row_Count   <= row_nxt;
            o_HSync       <= (col_nxt < ACT_COLS);
            o_VSync       <= (row_nxt < ACT_ROWS);
            o_Frame_Start <= (col_nxt == '0) && (row_nxt == '0);
        end
    end

    // Porch-applied syncs and active flag for the current count, before alignment.
    always_comb begin
        hsync_pre  = ~in_window(o_Col_Count, HS_FIRST, HS_LAST);
        vsync_pre  = ~in_window(o_Row_Count, VS_FIRST, VS_LAST);
        active_pre = o_HSync & o_VSync;
        pipe_in    = {hsync_pre, vsync_pre, active_pre};
    end

    if (VIDEO_DELAY == 0) begin : g_no_delay
        assign pipe_out = pipe_in;
    end else begin : g_delay
        vga_delay_line #(
            .WIDTH   (3),
            .DEPTH   (VIDEO_DELAY),
            .RST_VAL (PIPE_IDLE)
        ) u_delay (
            .clk   (i_Clk),
            .rst_n (i_Rst_L),
            .din   (pipe_in),
            .dout  (pipe_out)
        );
    end

    // Output stage: sample the game's colour and blank it outside the delayed active area.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_VGA_HSync <= 1'b1;
            o_VGA_VSync <= 1'b1;
            o_VGA_Red   <= '0;
            o_VGA_Grn   <= '0;
            o_VGA_Blu   <= '0;
        end else begin
            o_VGA_HSync <= pipe_out[2];
            o_VGA_VSync <= pipe_out[1];
            o_VGA_Red   <= pipe_out[0] ? i_Red_Video : '0;
            o_VGA_Grn   <= pipe_out[0] ? i_Grn_Video : '0;
            o_VGA_Blu   <= pipe_out[0] ? i_Blu_Video : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced raster, with VIDEO_DELAY=2 and 0 instances.
module tb_vga_sync_gen;

    localparam int TC = 40;
    localparam int TR = 20;
    localparam int AC = 24;
    localparam int AR = 12;
    localparam int FPH = 3;
    localparam int BPH = 5;
    localparam int FPV = 2;
    localparam int BPV = 3;
    localparam int DA = 2;
    localparam int DB = 0;
    localparam int FRAME = TC * TR;
    localparam int HSZ = 8192;

    typedef struct {
        int col; int row; int hs; int vs; int fs;
        int vhs; int vvs; int r; int g; int b;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] red = '0, grn = '0, blu = '0;

    logic a_hs, a_vs, a_fs, a_vhs, a_vvs;
    logic [9:0] a_col, a_row;
    logic [3:0] a_r, a_g, a_b;
    logic b_hs, b_vs, b_fs, b_vhs, b_vvs;
    logic [9:0] b_col, b_row;
    logic [3:0] b_r, b_g, b_b;

    int tests = 0;
    int fails = 0;
    int n;
    logic [11:0] hist [HSZ];

    always #5 clk = ~clk;

    vga_sync_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .FRONT_PORCH_HORZ(FPH), .BACK_PORCH_HORZ(BPH),
        .FRONT_PORCH_VERT(FPV), .BACK_PORCH_VERT(BPV), .VIDEO_DELAY(DA)
    ) dut_a (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_Red_Video(red), .i_Grn_Video(grn), .i_Blu_Video(blu),
        .o_HSync(a_hs), .o_VSync(a_vs), .o_Col_Count(a_col), .o_Row_Count(a_row),
        .o_Frame_Start(a_fs), .o_VGA_HSync(a_vhs), .o_VGA_VSync(a_vvs),
        .o_VGA_Red(a_r), .o_VGA_Grn(a_g), .o_VGA_Blu(a_b)
    );

    vga_sync_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .FRONT_PORCH_HORZ(FPH), .BACK_PORCH_HORZ(BPH),
        .FRONT_PORCH_VERT(FPV), .BACK_PORCH_VERT(BPV), .VIDEO_DELAY(DB)
    ) dut_b (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_Red_Video(red), .i_Grn_Video(grn), .i_Blu_Video(blu),
        .o_HSync(b_hs), .o_VSync(b_vs), .o_Col_Count(b_col), .o_Row_Count(b_row),
        .o_Frame_Start(b_fs), .o_VGA_HSync(b_vhs), .o_VGA_VSync(b_vvs),
        .o_VGA_Red(b_r), .o_VGA_Grn(b_g), .o_VGA_Blu(b_b)
    );

    // Edges since reset release, and the colour present at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0;
        end else begin
            n <= n + 1;
            hist[(n + 1) % HSZ] <= {red, grn, blu};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t n=%0d)", name, act, exp, $time, n);
        end
    endtask

    // Raster position after nn edges is nn laid out row-major; outputs of the
    // VGA stage after edge nn describe position nn-1-d with the colour seen at edge nn.
    function automatic obs_t model(input int nn, input int d, input logic [11:0] c);
        obs_t e;
        int k, kc, kr;
        bit act;
        e.col = nn % TC;
        e.row = (nn / TC) % TR;
        e.hs  = (nn > 0 && e.col < AC) ? 1 : 0;
        e.vs  = (nn > 0 && e.row < AR) ? 1 : 0;
        e.fs  = (nn > 0 && e.col == 0 && e.row == 0) ? 1 : 0;
        k = nn - 1 - d;
        if (k < 0) begin
            e.vhs = 1; e.vvs = 1; e.r = 0; e.g = 0; e.b = 0;
        end else begin
            kc = k % TC;
            kr = (k / TC) % TR;
            e.vhs = (kc >= AC + FPH && kc <= TC - BPH - 1) ? 0 : 1;
            e.vvs = (kr >= AR + FPV && kr <= TR - BPV - 1) ? 0 : 1;
            act = (k > 0 && kc < AC && kr < AR);
            e.r = act ? int'(c[11:8]) : 0;
            e.g = act ? int'(c[7:4])  : 0;
            e.b = act ? int'(c[3:0])  : 0;
        end
        return e;
    endfunction

    task automatic cmp_obs(input string tag, input obs_t act, input obs_t exp);
        chk({tag, "_col"}, act.col, exp.col);
        chk({tag, "_row"}, act.row, exp.row);
        chk({tag, "_hsync"}, act.hs, exp.hs);
        chk({tag, "_vsync"}, act.vs, exp.vs);
        chk({tag, "_frame_start"}, act.fs, exp.fs);
        chk({tag, "_vga_hsync"}, act.vhs, exp.vhs);
        chk({tag, "_vga_vsync"}, act.vvs, exp.vvs);
        chk({tag, "_red"}, act.r, exp.r);
        chk({tag, "_grn"}, act.g, exp.g);
        chk({tag, "_blu"}, act.b, exp.b);
    endtask

    // Every cycle, both instances against the model (reset values while n==0).
    always @(negedge clk) begin
        obs_t oa, ob;
        oa = '{int'(a_col), int'(a_row), int'(a_hs), int'(a_vs), int'(a_fs),
               int'(a_vhs), int'(a_vvs), int'(a_r), int'(a_g), int'(a_b)};
        ob = '{int'(b_col), int'(b_row), int'(b_hs), int'(b_vs), int'(b_fs),
               int'(b_vhs), int'(b_vvs), int'(b_r), int'(b_g), int'(b_b)};
        cmp_obs("a", oa, model(n, DA, hist[n % HSZ]));
        cmp_obs("b", ob, model(n, DB, hist[n % HSZ]));
    end

    task automatic step(input bit hold_red);
        @(posedge clk);
        #1;
        if (!hold_red) red = 4'($urandom_range(0, 15));
        grn = 4'($urandom_range(0, 15));
        blu = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int a_hl, a_vl, a_fc, b_hl, b_vl, b_fc, a_rf, b_rf, a_r0, b_r0;
        bit found;

        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        // First edge after release.
        @(posedge clk);
        #1;
        chk("first_col", int'(a_col), 1);
        chk("first_row", int'(a_row), 0);
        chk("first_hsync", int'(a_hs), 1);
        chk("first_vsync", int'(a_vs), 1);
        chk("first_frame_start", int'(a_fs), 0);

        // Rest of line 0 and the row step at the wrap.
        repeat (TC - 2) step(1'b0);
        chk("line_end_col", int'(a_col), TC - 1);
        chk("line_end_row", int'(a_row), 0);
        step(1'b0);
        chk("wrap_col", int'(a_col), 0);
        chk("wrap_row", int'(a_row), 1);

        repeat (2 * FRAME) step(1'b0);

        // One frame of observation: sync low lengths and frame-start count.
        a_hl = 0; a_vl = 0; a_fc = 0; b_hl = 0; b_vl = 0; b_fc = 0;
        repeat (FRAME) begin
            step(1'b0);
            if (!a_vhs) a_hl++;
            if (!a_vvs) a_vl++;
            if (a_fs) begin
                a_fc++;
                chk("fs_counts_a", int'(a_col) + int'(a_row), 0);
            end
            if (!b_vhs) b_hl++;
            if (!b_vvs) b_vl++;
            if (b_fs) b_fc++;
        end
        chk("hsync_low_per_frame_a", a_hl, 160);
        chk("vsync_low_per_frame_a", a_vl, 120);
        chk("frame_pulses_a", a_fc, 1);
        chk("hsync_low_per_frame_b", b_hl, 160);
        chk("vsync_low_per_frame_b", b_vl, 120);
        chk("frame_pulses_b", b_fc, 1);

        // Red held at F: only the 24x12 active area shows it.
        red = 4'hF;
        repeat (50) step(1'b1);
        a_rf = 0; b_rf = 0; a_r0 = 0; b_r0 = 0;
        repeat (FRAME) begin
            step(1'b1);
            if (a_r == 4'hF) a_rf++;
            if (a_r == 4'h0) a_r0++;
            if (b_r == 4'hF) b_rf++;
            if (b_r == 4'h0) b_r0++;
        end
        chk("red_full_a", a_rf, 288);
        chk("red_zero_a", a_r0, FRAME - 288);
        chk("red_full_b", b_rf, 288);
        chk("red_zero_b", b_r0, FRAME - 288);

        // Reset inside both sync pulses.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0);
            if (a_col == 10'd33 && a_row == 10'd15) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            chk("reset_point_reached", 0, 1);
        end else begin
            chk("pre_reset_vga_hsync", int'(a_vhs), 0);
            chk("pre_reset_vga_vsync", int'(a_vvs), 0);
            #2;
            rst_n = 1'b0;
            #1;
            chk("async_vga_hsync_a", int'(a_vhs), 1);
            chk("async_vga_vsync_a", int'(a_vvs), 1);
            chk("async_col_a", int'(a_col), 0);
            chk("async_row_a", int'(a_row), 0);
            chk("async_red_b", int'(b_r), 0);
            chk("async_vga_hsync_b", int'(b_vhs), 1);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk("restart_col", int'(a_col), 1);
            chk("restart_row", int'(a_row), 0);
            repeat (2 * FRAME) step(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: i_Clk (rising edge) and i_Rst_L (0 = reset).
REQ-002 Parameters SHALL be:
- TOTAL_COLS, default 800, clocks per line.
- TOTAL_ROWS, default 525, lines per frame.
- ACTIVE_COLS, default 640, visible columns.
- ACTIVE_ROWS, default 480, visible rows.
- FRONT_PORCH_HORZ, default 18, horizontal front porch in clocks.
- BACK_PORCH_HORZ, default 50, horizontal back porch in clocks.
- FRONT_PORCH_VERT, default 10, vertical front porch in lines.
- BACK_PORCH_VERT, default 33, vertical back porch in lines.
- VIDEO_DELAY, default 2, range 0..7, game pixel latency in clocks.
REQ-003 Ports SHALL be:
- i_Clk  in  1  pixel clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Red_Video / i_Grn_Video / i_Blu_Video  in  4 each  game pixel colour.
- o_HSync  out  1  raw horizontal active flag, 1 while column < ACTIVE_COLS.
- o_VSync  out  1  raw vertical active flag, 1 while row < ACTIVE_ROWS.
- o_Col_Count  out  10  current column.
- o_Row_Count  out  10  current row.
- o_Frame_Start  out  1  one-clock pulse at column 0, row 0.
- o_VGA_HSync  out  1  porch-applied horizontal sync, active low.
- o_VGA_VSync  out  1  porch-applied vertical sync, active low.
- o_VGA_Red / o_VGA_Grn / o_VGA_Blu  out  4 each  blanked, aligned colour.

Function
REQ-004 o_Col_Count SHALL increment by 1 each clock and wrap from TOTAL_COLS-1 to 0.
REQ-005 o_Row_Count SHALL increment by 1 on each column wrap and wrap from TOTAL_ROWS-1 to 0 on the same clock that the column wraps.
REQ-006 o_HSync, o_VSync and o_Frame_Start SHALL be registered and SHALL be consistent with the o_Col_Count/o_Row_Count values present in the same cycle, i.e. computed from the next-state counts.
REQ-007 o_Frame_Start SHALL be 1 for exactly one clock per frame: when the counts read (0,0) after a wrap.
REQ-008 The horizontal sync window SHALL be columns ACTIVE_COLS+FRONT_PORCH_HORZ through TOTAL_COLS-BACK_PORCH_HORZ-1 inclusive (658..749 at defaults).
REQ-009 The vertical sync window SHALL be rows ACTIVE_ROWS+FRONT_PORCH_VERT through TOTAL_ROWS-BACK_PORCH_VERT-1 inclusive (490..491 at defaults).
REQ-010 The pre-delay sync SHALL be 0 inside its window and 1 elsewhere.
REQ-011 The pre-delay sync and the active flag (o_HSync AND o_VSync) SHALL pass through a VIDEO_DELAY-stage shift register and then one output register.
REQ-012 Colour inputs SHALL be registered once, so that the colour the game drives VIDEO_DELAY clocks after count c appears on o_VGA_* together with the sync and active state of count c, VIDEO_DELAY+1 clocks after count c.
REQ-013 o_VGA_Red, o_VGA_Grn and o_VGA_Blu SHALL be 0 whenever the delayed active flag is 0, regardless of the colour inputs.
REQ-014 With VIDEO_DELAY = 0, the shift register SHALL be bypassed and the total latency SHALL be 1 clock.
REQ-015 Width rule: counts SHALL be 10 bits; parameters larger than 1023 SHALL be rejected at elaboration.

Reset
REQ-016 While i_Rst_L = 0, the following SHALL hold:
- Counts = 0.
- o_HSync = o_VSync = o_Frame_Start = 0.
- o_VGA_HSync = o_VGA_VSync = 1 (inactive).
- o_VGA_* colour outputs = 0.
- All delay stages cleared to inactive / blank.
REQ-017 On the first rising edge after deassertion, counts SHALL become (1,0) and o_HSync = o_VSync = 1; no o_Frame_Start pulse SHALL occur until the first wrap.
REQ-018 Reset asserted mid-frame SHALL take effect immediately (asynchronously), with no partial sync pulse after release.

Structure
REQ-019 The 640x480 timing constants and colour-width constants SHALL live in the shared package vga_timing_pkg.
REQ-020 The shift register SHALL be the sub-module vga_delay_line, parameterised by width and depth, with the same asynchronous reset.

Verification
REQ-021 Reset release, then 800 clocks -> o_Col_Count sequence 1..799,0 and o_Row_Count stepping 0->1 at the wrap.
REQ-022 Full frame (420000 clocks) -> exactly one o_Frame_Start pulse, with counts (0,0) in that cycle.
REQ-023 Defaults, row 100 -> o_VGA_HSync low for exactly 92 clocks, corresponding to columns 658..749 delayed by 3 clocks.
REQ-024 Defaults -> o_VGA_VSync low for exactly 1600 clocks (rows 490..491).
REQ-025 i_Red_Video = 4'hF held constant -> o_VGA_Red = F only for the 640 active columns of rows 0..479 (shifted by 3 clocks) and 0 elsewhere.
REQ-026 i_Rst_L pulsed low at column 700, row 490 -> o_VGA_HSync and o_VGA_VSync go to 1 immediately; after release the counts restart at (1,0).
